// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with a 2-entry skid buffer and fully registered in_ready.
// Optional stall/bubble counters are enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid_reg #(
    parameter int DATA_W        = 32,
    parameter bit ZERO_ON_FLUSH = 1'b1
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    parameter int CNT_W         = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);
    // state bits are {main_v, skid_v}, so both handshake outputs come straight from flops
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b10,
        FULL  = 2'b11
    } state_t;
    state_t            state_q;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;
    assign out_valid = state_q[1];
    assign in_ready  = !state_q[0];
    assign out_data  = main_data_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end
        end else begin
            case (state_q)
                EMPTY: if (in_valid) begin
                    main_data_q <= in_data;
                    state_q     <= HALF;
                end
                HALF: if (in_valid && out_ready) begin
                    main_data_q <= in_data;
                end else if (in_valid) begin
                    skid_data_q <= in_data;
                    state_q     <= FULL;
                end else if (out_ready) begin
                    state_q <= EMPTY;
                end
                FULL: if (out_ready) begin
                    main_data_q <= skid_data_q;
                    state_q     <= HALF;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
`ifdef PIPE_STAGE_SKID_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed and random checks of pipe_stage_skid_reg against a queue model.
module tb_pipe_stage_skid_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq[$];
    logic [31:0] stale = '0;
    logic [31:0] hold;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DATA_W(32), .ZERO_ON_FLUSH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, mq.size() > 0});
        chk({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, mq.size() < 2});
        chk({tag, " out_data"}, out_data, mq.size() > 0 ? mq[0] : stale);
    endtask

    task automatic model_reset();
        mq.delete();
        stale = '0;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f, input string tag);
        bit inf, outf;
        in_valid = v; in_data = d; out_ready = r; flush = f;
        @(posedge clk);
        inf  = v && mq.size() < 2;
        outf = mq.size() > 0 && r;
        if (f) begin
            mq.delete();
            stale = '0;
        end else begin
            if (outf) stale = mq.pop_front();
            if (inf) mq.push_back(d);
        end
        #1 check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, " rst out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " rst out_data"}, out_data, 32'd0);
        chk({tag, " rst in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, "basic");
        chk("basic word", out_data, 32'hA5A5A5A5);
        step(1'b0, 32'h0, 1'b1, 1'b0, "basic drain");
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i, 1'b1, 1'b0, "stream");
            chk("stream word", out_data, i);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, "stream drain");
        step(1'b1, 32'd1, 1'b0, 1'b0, "bp1");
        step(1'b1, 32'd2, 1'b0, 1'b0, "bp2");
        chk("bp full", {31'b0, in_ready}, 32'd0);
        step(1'b1, 32'd3, 1'b0, 1'b0, "bp3");
        chk("bp head", out_data, 32'd1);
        step(1'b1, 32'd3, 1'b1, 1'b0, "bp release");
        chk("bp order2", out_data, 32'd2);
        step(1'b1, 32'd3, 1'b1, 1'b0, "bp push3");
        chk("bp order3", out_data, 32'd3);
        step(1'b0, 32'd0, 1'b1, 1'b0, "bp drain");
        step(1'b1, 32'h11, 1'b0, 1'b0, "fl fill1");
        step(1'b1, 32'h22, 1'b0, 1'b0, "fl fill2");
        step(1'b1, 32'h55, 1'b0, 1'b1, "flush");
        chk("flush data zero", out_data, 32'd0);
        chk("flush ready", {31'b0, in_ready}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, "post flush");
        step(1'b1, 32'hCAFE, 1'b0, 1'b0, "stab fill");
        hold = out_data;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, "stab");
            chk("stable data", out_data, hold);
        end
        step(1'b1, 32'hBEEF, 1'b0, 1'b0, "mid fill");
        async_reset("mid");
        step(1'b1, 32'h77, 1'b1, 1'b0, "post reset");
        chk("post reset word", out_data, 32'h77);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 30) == 0), "rand");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
